// File: rtl/rgb_pwm_pkg.sv
// rtl/rgb_pwm_pkg.sv - shared types for the RGB LED PWM controller
package rgb_pwm_pkg;

   localparam int MAX_CHAN_W = 3;
   localparam int MAX_PWM_W  = 16;

   typedef enum logic [1:0] {
      MODE_OFF     = 2'd0,
      MODE_STATIC  = 2'd1,
      MODE_BLINK   = 2'd2,
      MODE_BREATHE = 2'd3
   } led_mode_t;

   typedef struct packed {
      logic [MAX_CHAN_W-1:0] chan;
      led_mode_t             mode;
      logic [MAX_PWM_W-1:0]  level;
   } pending_cfg_t;

endpackage

// File: rtl/rgb_pwm_channel.sv
// rtl/rgb_pwm_channel.sv - one PWM channel: mode state, frame-rate effects, duty compare
module rgb_pwm_channel
   import rgb_pwm_pkg::*;
#(
   parameter int W              = 8,
   parameter int BLINK_FRAMES   = 250,
   parameter int BREATHE_FRAMES = 2
) (
   input  logic         clk_48mhz,
   input  logic         reset_n,
   input  logic         fb_i,
   input  logic         apply_i,
   input  led_mode_t    mode_i,
   input  logic [W-1:0] level_i,
   input  logic [W-1:0] pwm_cnt_i,
   output logic         pwm_o
);

   localparam int DIV_MAX = (BLINK_FRAMES > BREATHE_FRAMES) ? BLINK_FRAMES : BREATHE_FRAMES;
   localparam int DIV_W   = (DIV_MAX > 1) ? $clog2(DIV_MAX + 1) : 1;

   led_mode_t        mode_q, mode_d;
   logic [W-1:0]     level_q, level_d;
   logic [W-1:0]     ramp_q, ramp_d;
   logic             dir_q, dir_d;
   logic             blink_q, blink_d;
   logic [DIV_W-1:0] div_q, div_d;
   logic [W-1:0]     duty_q, duty_d;
   logic             pwm_q;
   logic             frame_evt;
   logic             blink_now;

   always_comb begin
      mode_d    = mode_q;
      level_d   = level_q;
      ramp_d    = ramp_q;
      dir_d     = dir_q;
      blink_d   = blink_q;
      div_d     = div_q;
      duty_d    = duty_q;
      frame_evt = 1'b0;
      blink_now = blink_q;
      if (fb_i) begin
         if (apply_i) begin
            mode_d  = mode_i;
            level_d = level_i;
            ramp_d  = '0;
            dir_d   = 1'b0;
            blink_d = 1'b1;
            div_d   = '0;
         end
         // Blink duty follows the half-period this frame belongs to, before any toggle.
         blink_now = blink_d;
         frame_evt = (div_d == ((mode_d == MODE_BLINK) ? DIV_W'(BLINK_FRAMES - 1)
                                                       : DIV_W'(BREATHE_FRAMES - 1)));
         div_d = frame_evt ? '0 : div_d + DIV_W'(1);
         if (mode_d == MODE_BLINK && frame_evt)
            blink_d = ~blink_d;
         if (mode_d == MODE_BREATHE) begin
            if (level_d == '0) begin
               ramp_d = '0;
               dir_d  = 1'b0;
            end else if (frame_evt) begin
               if (!dir_d) begin
                  ramp_d = ramp_d + W'(1);
                  if (ramp_d == level_d) dir_d = 1'b1;
               end else begin
                  ramp_d = ramp_d - W'(1);
                  if (ramp_d == '0) dir_d = 1'b0;
               end
            end
         end
         case (mode_d)
            MODE_OFF:    duty_d = '0;
            MODE_STATIC: duty_d = level_d;
            MODE_BLINK:  duty_d = blink_now ? level_d : '0;
            default:     duty_d = ramp_d;
         endcase
      end
   end

   always_ff @(posedge clk_48mhz or negedge reset_n) begin
      if (!reset_n) begin
         mode_q  <= MODE_OFF;
         level_q <= '0;
         ramp_q  <= '0;
         dir_q   <= 1'b0;
         blink_q <= 1'b1;
         div_q   <= '0;
         duty_q  <= '0;
         pwm_q   <= 1'b0;
      end else begin
         mode_q  <= mode_d;
         level_q <= level_d;
         ramp_q  <= ramp_d;
         dir_q   <= dir_d;
         blink_q <= blink_d;
         div_q   <= div_d;
         duty_q  <= duty_d;
         pwm_q   <= (duty_q == '1) | (pwm_cnt_i < duty_q);
      end
   end

   assign pwm_o = pwm_q;

endmodule

// File: rtl/rgb_pwm_ctrl.sv
// rtl/rgb_pwm_ctrl.sv - multi-channel LED PWM controller: prescaler, frame counter, config slot
module rgb_pwm_ctrl
   import rgb_pwm_pkg::*;
#(
   parameter int CHANNELS       = 3,
   parameter int PWM_WIDTH      = 8,
   parameter int PRESCALE       = 188,
   parameter int BLINK_FRAMES   = 250,
   parameter int BREATHE_FRAMES = 2,
   localparam int CHAN_W        = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
   input  logic                 clk_48mhz,
   input  logic                 reset_n,
   input  logic                 cfg_valid,
   output logic                 cfg_ready,
   input  logic [CHAN_W-1:0]    cfg_chan,
   input  logic [1:0]           cfg_mode,
   input  logic [PWM_WIDTH-1:0] cfg_level,
   output logic [CHANNELS-1:0]  pwm_out,
   output logic                 frame_tick
);

   localparam int PRE_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

   logic [PRE_W-1:0]     pre_cnt_q;
   logic [PWM_WIDTH-1:0] pwm_cnt_q;
   logic                 pend_valid_q;
   pending_cfg_t         pend_q;
   logic                 frame_tick_q;
   logic                 step;
   logic                 fb;
   logic                 unused_pend_level;

   assign step      = (pre_cnt_q == PRE_W'(PRESCALE - 1));
   assign fb        = step && (pwm_cnt_q == '1);
   assign cfg_ready = ~pend_valid_q;

   always_ff @(posedge clk_48mhz or negedge reset_n) begin
      if (!reset_n) begin
         pre_cnt_q    <= '0;
         pwm_cnt_q    <= '0;
         pend_valid_q <= 1'b0;
         pend_q       <= '0;
         frame_tick_q <= 1'b0;
      end else begin
         pre_cnt_q    <= step ? '0 : pre_cnt_q + PRE_W'(1);
         if (step) pwm_cnt_q <= pwm_cnt_q + PWM_WIDTH'(1);
         frame_tick_q <= fb;
         // Slot is empty when a transfer happens, so accept and apply never collide.
         if (cfg_valid && !pend_valid_q) begin
            pend_valid_q <= 1'b1;
            pend_q.chan  <= MAX_CHAN_W'(cfg_chan);
            pend_q.mode  <= led_mode_t'(cfg_mode);
            pend_q.level <= MAX_PWM_W'(cfg_level);
         end else if (fb) begin
            pend_valid_q <= 1'b0;
         end
      end
   end

   assign unused_pend_level = ^pend_q.level;

   for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
      rgb_pwm_channel #(
         .W              (PWM_WIDTH),
         .BLINK_FRAMES   (BLINK_FRAMES),
         .BREATHE_FRAMES (BREATHE_FRAMES)
      ) u_chan (
         .clk_48mhz (clk_48mhz),
         .reset_n   (reset_n),
         .fb_i      (fb),
         .apply_i   (pend_valid_q && (pend_q.chan == MAX_CHAN_W'(i))),
         .mode_i    (pend_q.mode),
         .level_i   (pend_q.level[PWM_WIDTH-1:0]),
         .pwm_cnt_i (pwm_cnt_q),
         .pwm_o     (pwm_out[i])
      );
   end

   assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_rgb_pwm_ctrl.sv
// tb/tb_rgb_pwm_ctrl.sv - directed scoreboard bench for rgb_pwm_ctrl
module tb_rgb_pwm_ctrl;

   logic       clk_48mhz = 1'b0;
   logic       reset_n   = 1'b0;
   logic       cfg_valid = 1'b0;
   logic       cfg_ready;
   logic [1:0] cfg_chan  = '0;
   logic [1:0] cfg_mode  = '0;
   logic [3:0] cfg_level = '0;
   logic [2:0] pwm_out;
   logic       frame_tick;

   int n_vec = 0;
   int n_err = 0;
   logic [14:0] sb_q[$];

   rgb_pwm_ctrl #(
      .CHANNELS(3), .PWM_WIDTH(4), .PRESCALE(1), .BLINK_FRAMES(2), .BREATHE_FRAMES(1)
   ) dut (
      .clk_48mhz (clk_48mhz),
      .reset_n   (reset_n),
      .cfg_valid (cfg_valid),
      .cfg_ready (cfg_ready),
      .cfg_chan  (cfg_chan),
      .cfg_mode  (cfg_mode),
      .cfg_level (cfg_level),
      .pwm_out   (pwm_out),
      .frame_tick(frame_tick)
   );

   always #5 clk_48mhz = ~clk_48mhz;

   initial begin
      #200000;
      $display("FAIL watchdog: observed no finish, expected finish");
      $fatal(1);
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic push(input int a, input int b, input int c, input int n);
      logic [14:0] v;
      v = {5'(c), 5'(b), 5'(a)};
      repeat (n) sb_q.push_back(v);
   endtask

   task automatic wait_ready(input string tag, output int k);
      k = 0;
      while (!cfg_ready && k < 80) begin
         @(negedge clk_48mhz);
         k++;
      end
      check(tag, cfg_ready, 1);
   endtask

   task automatic send(input int ch, input int mode, input int lvl);
      int k;
      @(negedge clk_48mhz);
      cfg_chan  = ch[1:0];
      cfg_mode  = mode[1:0];
      cfg_level = lvl[3:0];
      cfg_valid = 1'b1;
      wait_ready("send_ready", k);
      @(posedge clk_48mhz);
      @(negedge clk_48mhz);
      cfg_valid = 1'b0;
      check("ready_drop", cfg_ready, 0);
   endtask

   task automatic wait_applied();
      int k;
      wait_ready("apply_ready", k);
      check("apply_tick", frame_tick, 1);
   endtask

   task automatic measure(input int n);
      int cnt[3];
      logic [14:0] exp;
      for (int f = 0; f < n; f++) begin
         for (int c = 0; c < 3; c++) cnt[c] = 0;
         for (int k = 0; k < 16; k++) begin
            @(negedge clk_48mhz);
            for (int c = 0; c < 3; c++) cnt[c] += int'(pwm_out[c]);
         end
         check("frame_tick_period", frame_tick, 1);
         if (sb_q.size() == 0) begin
            n_vec++;
            n_err++;
            $error("FAIL sb_underflow: observed empty queue expected entry");
         end else begin
            exp = sb_q.pop_front();
            for (int c = 0; c < 3; c++)
               check($sformatf("duty_ch%0d_f%0d", c, f), cnt[c], 32'(exp[c*5 +: 5]));
         end
      end
   endtask

   initial begin
      int k;
      repeat (3) @(negedge clk_48mhz);
      check("rst_ready", cfg_ready, 1);
      check("rst_pwm", pwm_out, 0);
      check("rst_tick", frame_tick, 0);
      reset_n = 1'b1;

      send(0, 1, 4);  wait_applied(); push(4, 0, 0, 2);  measure(2);
      send(1, 1, 15); wait_applied(); push(4, 16, 0, 1); measure(1);
      send(1, 1, 0);  wait_applied(); push(4, 0, 0, 1);  measure(1);

      send(2, 2, 8);  wait_applied();
      push(4, 0, 8, 2); push(4, 0, 0, 2); push(4, 0, 8, 1);
      measure(5);
      send(2, 0, 0);  wait_applied(); push(4, 0, 0, 1); measure(1);

      // back-to-back configs with cfg_valid held
      @(negedge clk_48mhz);
      cfg_chan = 2'd1; cfg_mode = 2'd1; cfg_level = 4'd2; cfg_valid = 1'b1;
      wait_ready("hs_a_ready", k);
      @(posedge clk_48mhz);
      @(negedge clk_48mhz);
      cfg_chan = 2'd2; cfg_level = 4'd6;
      check("hs_ready_drop", cfg_ready, 0);
      wait_ready("hs_a_apply", k);
      check("hs_a_tick", frame_tick, 1);
      @(posedge clk_48mhz);
      @(negedge clk_48mhz);
      cfg_valid = 1'b0;
      check("hs_b_ready_drop", cfg_ready, 0);
      wait_ready("hs_b_apply", k);
      check("hs_b_latency", k, 15);
      check("hs_b_tick", frame_tick, 1);
      push(4, 2, 6, 1); measure(1);

      send(3, 1, 9); wait_applied(); push(4, 2, 6, 1); measure(1);

      send(0, 3, 3); wait_applied();
      push(1, 2, 6, 1); push(2, 2, 6, 1); push(3, 2, 6, 1); push(2, 2, 6, 1);
      push(1, 2, 6, 1); push(0, 2, 6, 1); push(1, 2, 6, 1); push(2, 2, 6, 1);
      measure(8);

      send(0, 1, 15);
      k = 0;
      while (pwm_out == 3'b000 && k < 20) begin
         @(negedge clk_48mhz);
         k++;
      end
      check("pre_reset_pending", cfg_ready, 0);
      check("pre_reset_active", (pwm_out != 3'b000), 1);
      #1 reset_n = 1'b0;
      #1;
      check("async_pwm", pwm_out, 0);
      check("async_ready", cfg_ready, 1);
      check("async_tick", frame_tick, 0);
      repeat (2) @(negedge clk_48mhz);
      reset_n = 1'b1;
      check("post_reset_ready", cfg_ready, 1);
      k = 0;
      while (!frame_tick && k < 40) begin
         @(negedge clk_48mhz);
         k++;
      end
      check("post_reset_tick", frame_tick, 1);
      push(0, 0, 0, 2); measure(2);
      check("post_reset_idle_ready", cfg_ready, 1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
